inst_fetch_queue: RTL and testbench
===================================

INST_FETCH_QUEUE -- requirements
Module: inst_fetch_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction width.
REQ-002 SHALL have parameter ADDR_W, default 32: fetch address width.
REQ-003 SHALL have parameter DEPTH, default 4: queue entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 32'hBFC0_0000: first fetch address after reset.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have port ibus_en, output, 1: fetch request valid.
REQ-008 SHALL have port ibus_addr, output, ADDR_W: fetch address.
REQ-009 SHALL have port ibus_ready, input, 1: request accepted when ibus_en is also high.
REQ-010 SHALL have port ibus_rvalid, input, 1: read data valid; responses return in request order.
REQ-011 SHALL have port ibus_rdata, input, DATA_W: read data.
REQ-012 SHALL have port out_valid, output, 1: queue head holds a valid instruction.
REQ-013 SHALL have port out_pc, output, ADDR_W: PC of the head entry.
REQ-014 SHALL have port out_inst, output, DATA_W: instruction of the head entry.
REQ-015 SHALL have port out_ready, input, 1: decode consumes the head; low means stall.
REQ-016 SHALL have port flush, input, 1: redirect request from branch or exception.
REQ-017 SHALL have port flush_pc, input, ADDR_W: redirect target.
REQ-018 SHALL have port count, output, clog2(DEPTH)+1: number of valid entries.

Function
REQ-019 SHALL keep fetch PC register fpc; a request is accepted when ibus_en and ibus_ready are both high, and fpc then advances by 4 with modulo 2^ADDR_W wrap.
REQ-020 SHALL drive ibus_en high only when count + outstanding < DEPTH and flush is low; outstanding counts accepted requests whose responses have not yet returned.
REQ-021 SHALL hold ibus_addr equal to fpc, held stable while ibus_en is high and ibus_ready is low.
REQ-022 SHALL, on ibus_rvalid with the discard counter at zero, write {pc, ibus_rdata} at the write pointer; pc is the address of the oldest outstanding request, tracked through a per-entry PC pipeline.
REQ-023 SHALL pop the head when out_valid and out_ready are both high; head outputs SHALL be registered from storage with zero added latency, so out_valid is high the cycle after the write.
REQ-024 SHALL, on a simultaneous push and pop, keep count unchanged; pointers wrap modulo DEPTH.
REQ-025 SHALL, on flush, in the same cycle: clear count and pointers; load fpc from flush_pc; set the discard counter to outstanding plus any request accepted that cycle minus any response arriving that cycle; drop the response arriving that cycle.
REQ-026 SHALL, while the discard counter is nonzero, decrement it on each ibus_rvalid and drop that data.
REQ-027 SHALL give flush priority over push, pop and request acceptance; the first post-flush request is issued the cycle after flush.
REQ-028 SHALL never overflow the queue; an ibus_rvalid with no outstanding request is illegal and SHALL fire a simulation-only assertion.

Reset
REQ-029 SHALL, while rst is low, force ibus_en=0, out_valid=0, count=0, out_pc=0, out_inst=0, outstanding=0 and discard=0, and hold fpc at RESET_PC.
REQ-030 SHALL, in the first cycle after rst deasserts, drive ibus_en=1 with ibus_addr=RESET_PC.
REQ-031 SHALL, if reset is asserted mid-operation, drop all outstanding and queued state with no pending response replayed.

Structure
REQ-032 SHALL take RESET_PC default, the PC increment and bus-width macros from the shared defines package.
REQ-033 SHALL instantiate one storage sub-module, fetch_fifo (parametrised by width and DEPTH, holding pointers, count and storage); fetch sequencing and discard logic SHALL stay in the top.

Verification
REQ-034 SHALL cover zero-wait bus with out_ready=1: rvalid one cycle after accept; out_pc = BFC00000, BFC00004, BFC00008 on consecutive cycles.
REQ-035 SHALL cover stall: out_ready=0 for 10 cycles with DEPTH=4; count=4, ibus_en=0, no more than 4 requests issued; release drains in order.
REQ-036 SHALL cover flush with 2 requests outstanding and flush_pc=80000180: the 2 late responses are dropped and the next out_pc=80000180.
REQ-037 SHALL cover flush in the same cycle as ibus_rvalid and ibus_ready: the discard counter ends at the correct value and no stale instruction appears.
REQ-038 SHALL cover ibus_ready held low 5 cycles: ibus_addr stable and fpc not advanced.
REQ-039 SHALL cover asynchronous reset asserted mid-burst: outputs zero immediately; fetch restarts at BFC00000 after release.

Source files
------------

// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch-path constants: bus widths, boot vector and sequential PC step.
package inst_fetch_queue_pkg;
   localparam int          IFQ_DATA_W   = 32;
   localparam int          IFQ_ADDR_W   = 32;
   localparam logic [31:0] IFQ_RESET_PC = 32'hBFC0_0000;
   localparam int          IFQ_PC_INC   = 4;
endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// Instruction queue storage: circular buffer with pointers and occupancy count.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear_i,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic [WIDTH-1:0]         wdata_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     valid_o,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [CW-1:0]    count_q;
   logic             push, pop;

   assign valid_o = (count_q != '0);
   assign push    = push_i & (count_q != CW'(DEPTH));
   assign pop     = pop_i & valid_o;
   assign count_o = count_q;
   // Head is read straight from storage; zeroed when empty so stale entries never leak.
   assign rdata_o = valid_o ? mem_q[rptr_q] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else if (clear_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push && !clear_i) mem_q[wptr_q] <= wdata_i;
   end
endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch sequencer: issues sequential fetches, tracks in-flight PCs,
// discards responses belonging to requests issued before a redirect.
module inst_fetch_queue
   import inst_fetch_queue_pkg::*;
#(
   parameter int                DATA_W   = IFQ_DATA_W,
   parameter int                ADDR_W   = IFQ_ADDR_W,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(IFQ_RESET_PC)
) (
   input  logic                   clk,
   input  logic                   rst,
   output logic                   ibus_en,
   output logic [ADDR_W-1:0]      ibus_addr,
   input  logic                   ibus_ready,
   input  logic                   ibus_rvalid,
   input  logic [DATA_W-1:0]      ibus_rdata,
   output logic                   out_valid,
   output logic [ADDR_W-1:0]      out_pc,
   output logic [DATA_W-1:0]      out_inst,
   input  logic                   out_ready,
   input  logic                   flush,
   input  logic [ADDR_W-1:0]      flush_pc,
   output logic [$clog2(DEPTH):0] count
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0]        fpc_q, fpc_d;
   logic [CW-1:0]            outst_q, outst_d;
   logic [CW-1:0]            disc_q, disc_d;
   logic [ADDR_W-1:0]        pcq_q [DEPTH];
   logic [PW-1:0]            pcq_wp_q, pcq_rp_q;
   logic [CW:0]              occ;
   logic                     accept, push, pop;
   logic [ADDR_W+DATA_W-1:0] head;

   // Queue slots are reserved at request time, so a response always has room.
   assign occ       = {1'b0, count} + {1'b0, outst_q};
   assign ibus_en   = rst & ~flush & (occ < (CW+1)'(DEPTH));
   assign ibus_addr = fpc_q;
   assign accept    = ibus_en & ibus_ready;
   assign push      = ibus_rvalid & (disc_q == '0) & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_comb begin
      fpc_d   = fpc_q;
      outst_d = outst_q + CW'(accept) - CW'(ibus_rvalid);
      disc_d  = disc_q;
      if (flush)                          fpc_d = flush_pc;
      else if (accept)                    fpc_d = fpc_q + ADDR_W'(IFQ_PC_INC);
      // Everything still in flight after this cycle belongs to the old path.
      if (flush)                          disc_d = outst_d;
      else if (ibus_rvalid && disc_q != '0) disc_d = disc_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc_q    <= RESET_PC;
         outst_q  <= '0;
         disc_q   <= '0;
         pcq_wp_q <= '0;
         pcq_rp_q <= '0;
      end else begin
         fpc_q   <= fpc_d;
         outst_q <= outst_d;
         disc_q  <= disc_d;
         // PC pipeline stays aligned with the bus across flushes; dropped responses still retire their slot.
         if (accept)      pcq_wp_q <= pcq_wp_q + 1'b1;
         if (ibus_rvalid) pcq_rp_q <= pcq_rp_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) pcq_q[pcq_wp_q] <= fpc_q;
   end

   fetch_fifo #(
      .WIDTH (ADDR_W + DATA_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .clear_i (flush),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({pcq_q[pcq_rp_q], ibus_rdata}),
      .rdata_o (head),
      .valid_o (out_valid),
      .count_o (count)
   );

   assign out_pc   = head[ADDR_W+DATA_W-1:DATA_W];
   assign out_inst = head[DATA_W-1:0];

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (rst && ibus_rvalid)
         assert (outst_q != '0) else $error("ibus_rvalid with no outstanding request");
   end
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue with an in-order bus model and a program-order reference.
module tb_inst_fetch_queue;
   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'hBFC0_0000;

   logic        clk = 1'b0, rst = 1'b0;
   logic        ibus_en, ibus_ready, ibus_rvalid;
   logic [31:0] ibus_addr, ibus_rdata;
   logic        out_valid, out_ready, flush;
   logic [31:0] out_pc, out_inst, flush_pc;
   logic [2:0]  count;

   inst_fetch_queue #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(RPC)) dut (
      .clk(clk), .rst(rst),
      .ibus_en(ibus_en), .ibus_addr(ibus_addr), .ibus_ready(ibus_ready),
      .ibus_rvalid(ibus_rvalid), .ibus_rdata(ibus_rdata),
      .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_ready(out_ready),
      .flush(flush), .flush_pc(flush_pc), .count(count)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] addr; int due; } req_t;
   req_t        pend[$];
   logic [31:0] pop_pc[$];
   int          pop_cyc[$];
   int          n_chk = 0, n_err = 0, cyc = 0, last_due = 0, n_acc = 0;
   int          rdy_pct, ordy_pct, lat_lo, lat_hi, flush_pct, arm_pend;
   bit          arm_rsp, want_on;
   logic [31:0] arm_pc, want_pc, exp_fpc, exp_opc, held;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic cycle();
      bit   acc, pop, fl;
      req_t r;
      @(negedge clk);
      ibus_ready  = ($urandom_range(99) < rdy_pct);
      out_ready   = ($urandom_range(99) < ordy_pct);
      ibus_rvalid = 1'b0;
      ibus_rdata  = '0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
         ibus_rvalid = 1'b1;
         ibus_rdata  = memf(pend[0].addr);
      end
      fl = ($urandom_range(99) < flush_pct);
      flush_pc = $urandom & 32'hFFFF_FFFC;
      if ((arm_pend >= 0 && pend.size() == arm_pend) || (arm_rsp && ibus_rvalid && ibus_ready)) begin
         fl = 1'b1; flush_pc = arm_pc; want_pc = arm_pc; want_on = 1'b1;
         arm_pend = -1; arm_rsp = 1'b0;
      end
      flush = fl;
      #1;
      acc = ibus_en && ibus_ready;
      pop = out_valid && out_ready && !flush;
      chk("cnt_max", count <= DEPTH, 1);
      if (flush) chk("en_in_flush", ibus_en, 0);
      else       chk("en_rule", ibus_en, (count + pend.size()) < DEPTH);
      if (pop) begin
         if (want_on) begin chk("redirect_pc", out_pc, want_pc); want_on = 1'b0; end
         chk("out_pc", out_pc, exp_opc);
         chk("out_inst", out_inst, memf(exp_opc));
         pop_pc.push_back(out_pc); pop_cyc.push_back(cyc);
         exp_opc += 4;
      end
      if (ibus_rvalid) void'(pend.pop_front());
      if (acc) begin
         chk("ibus_addr", ibus_addr, exp_fpc);
         r.addr = exp_fpc;
         r.due  = cyc + int'($urandom_range(lat_hi, lat_lo));
         if (r.due <= last_due) r.due = last_due + 1;
         last_due = r.due;
         pend.push_back(r);
         exp_fpc += 4;
         n_acc++;
      end
      if (flush) begin exp_fpc = flush_pc; exp_opc = flush_pc; end
      cyc++;
   endtask

   task automatic knobs(input int rp, input int op, input int lo, input int hi, input int fp);
      rdy_pct = rp; ordy_pct = op; lat_lo = lo; lat_hi = hi; flush_pct = fp;
   endtask

   initial begin
      int snap;
      ibus_ready = 0; ibus_rvalid = 0; ibus_rdata = 0; out_ready = 0; flush = 0; flush_pc = 0;
      arm_pend = -1; arm_rsp = 0; want_on = 0;
      exp_fpc = RPC; exp_opc = RPC;
      repeat (3) @(negedge clk);
      chk("rst_en", ibus_en, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_pc", out_pc, 0);
      chk("rst_inst", out_inst, 0);
      rst = 1'b1;
      #1;
      chk("boot_en", ibus_en, 1);
      chk("boot_addr", ibus_addr, RPC);

      // zero-wait streaming
      knobs(100, 100, 1, 1, 0);
      repeat (8) cycle();
      chk("zw_pops", pop_pc.size() >= 3, 1);
      if (pop_pc.size() >= 3) begin
         chk("zw_pc0", pop_pc[0], 32'hBFC0_0000);
         chk("zw_pc1", pop_pc[1], 32'hBFC0_0004);
         chk("zw_pc2", pop_pc[2], 32'hBFC0_0008);
         chk("zw_lat", pop_cyc[0], 2);
         chk("zw_b2b1", pop_cyc[1], pop_cyc[0] + 1);
         chk("zw_b2b2", pop_cyc[2], pop_cyc[1] + 1);
      end

      // decode stall fills the queue and throttles fetch
      knobs(100, 0, 1, 1, 0);
      snap = n_acc;
      repeat (10) cycle();
      chk("stall_count", count, 4);
      chk("stall_en", ibus_en, 0);
      chk("stall_issued", (n_acc - snap) <= 4, 1);
      knobs(100, 100, 1, 1, 0);
      repeat (12) cycle();

      // flush with two requests in flight
      knobs(0, 100, 1, 1, 0);
      repeat (8) cycle();
      knobs(100, 100, 3, 3, 0);
      arm_pend = 2; arm_pc = 32'h8000_0180;
      repeat (16) cycle();
      chk("flush2_seen", want_on, 0);
      chk("flush2_armed", arm_pend, -1);

      // flush coincident with a response and a ready bus
      knobs(100, 100, 2, 2, 0);
      arm_rsp = 1'b1; arm_pc = 32'h0000_1000;
      repeat (16) cycle();
      chk("flushrsp_seen", want_on, 0);
      chk("flushrsp_armed", arm_rsp, 0);

      // bus backpressure holds the request
      knobs(0, 100, 1, 1, 0);
      repeat (6) cycle();
      held = exp_fpc;
      repeat (5) begin
         cycle();
         chk("hold_en", ibus_en, 1);
         chk("hold_addr", ibus_addr, held);
      end
      knobs(100, 100, 1, 1, 0);
      repeat (6) cycle();

      // asynchronous reset mid-burst
      knobs(100, 50, 2, 2, 0);
      repeat (6) cycle();
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("mrst_en", ibus_en, 0);
      chk("mrst_valid", out_valid, 0);
      chk("mrst_count", count, 0);
      chk("mrst_pc", out_pc, 0);
      chk("mrst_inst", out_inst, 0);
      ibus_ready = 0; ibus_rvalid = 0; flush = 0; out_ready = 0;
      pend.delete();
      exp_fpc = RPC; exp_opc = RPC; last_due = cyc;
      want_pc = RPC; want_on = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mrst_boot_en", ibus_en, 1);
      chk("mrst_boot_addr", ibus_addr, RPC);
      knobs(100, 100, 1, 1, 0);
      repeat (6) cycle();
      chk("mrst_restart", want_on, 0);

      // random traffic with occasional redirects
      knobs(70, 60, 1, 4, 2);
      repeat (1500) cycle();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
